// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator door/motor actuator block:
// door FSM and motor FSM state enums, door_state output codes, default timings.
package elevator_pkg;

    localparam int DEFAULT_DOOR_MOVE_TICKS = 32;
    localparam int DEFAULT_OPEN_TICKS      = 96;
    localparam int DEFAULT_RUN_TICKS       = 64;

    localparam logic [1:0] DS_CLOSED  = 2'b00;
    localparam logic [1:0] DS_OPENING = 2'b01;
    localparam logic [1:0] DS_OPEN    = 2'b10;
    localparam logic [1:0] DS_CLOSING = 2'b11;

    typedef enum logic [2:0] {
        D_IDLE,
        D_OPENING,
        D_OPEN,
        D_CLOSING,
        D_PULSE,
        D_WAIT
    } door_fsm_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_PULSE,
        M_WAIT
    } motor_fsm_t;

    // Idle, completion pulse and wait-for-release all present a closed door.
    function automatic logic [1:0] door_code(input door_fsm_t s);
        case (s)
            D_OPENING: return DS_OPENING;
            D_OPEN:    return DS_OPEN;
            D_CLOSING: return DS_CLOSING;
            default:   return DS_CLOSED;
        endcase
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Down-counting phase timer: load a value, count down while enabled, flag zero.
// reverse loads (value - count) so a reversed door motion mirrors the time already spent.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         reverse,
    input  logic         enable,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= reverse ? (value - count_reg) : value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/door_motor_timer.sv
// Actuator-side responder: times door open/dwell/close and one-floor runs,
// returns one-cycle completion pulses and enforces the door/motor interlock.
module door_motor_timer
    import elevator_pkg::*;
#(
    parameter int DOOR_MOVE_TICKS = DEFAULT_DOOR_MOVE_TICKS,
    parameter int OPEN_TICKS      = DEFAULT_OPEN_TICKS,
    parameter int RUN_TICKS       = DEFAULT_RUN_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch,
    input  logic       opendoor,
    input  logic       mv2nxt,
    input  logic       hold_btn,
    input  logic       obstruct,
    output logic       endOpen,
    output logic       endRun,
    output logic [1:0] door_state,
    output logic       motor_on,
    output logic       interlock
);

    localparam int MAX_TICKS = (DOOR_MOVE_TICKS > OPEN_TICKS)
                             ? ((DOOR_MOVE_TICKS > RUN_TICKS) ? DOOR_MOVE_TICKS : RUN_TICKS)
                             : ((OPEN_TICKS > RUN_TICKS) ? OPEN_TICKS : RUN_TICKS);
    localparam int CW = $clog2(MAX_TICKS + 1);
    localparam int TD = 0;
    localparam int TM = 1;

    // Timers are loaded with N-1: the load edge plus N-1 decrements gives N cycles in state.
    localparam logic [CW-1:0] MOVE_LOAD = CW'(DOOR_MOVE_TICKS - 1);
    localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_TICKS - 1);
    localparam logic [CW-1:0] RUN_LOAD  = CW'(RUN_TICKS - 1);

    logic        sync_rst;
    door_fsm_t   door_reg, door_next;
    motor_fsm_t  motor_reg, motor_next;
    logic        end_open_reg, end_run_reg, motor_on_reg, interlock_reg;
    logic [1:0]  door_state_reg;

    logic [1:0]    t_load, t_reverse, t_enable, t_zero;
    logic [CW-1:0] t_value [2];

    assign sync_rst = rst | ~switch;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_timer
            tick_timer #(.W(CW)) u_timer (
                .clk     (clk),
                .rst     (sync_rst),
                .load    (t_load[gi]),
                .reverse (t_reverse[gi]),
                .enable  (t_enable[gi]),
                .value   (t_value[gi]),
                .zero    (t_zero[gi])
            );
        end
    endgenerate

    always_comb begin
        door_next    = door_reg;
        t_load[TD]   = 1'b0;
        t_reverse[TD] = 1'b0;
        t_enable[TD] = 1'b0;
        t_value[TD]  = '0;
        case (door_reg)
            D_IDLE: begin
                if (opendoor && (motor_reg == M_IDLE)) begin
                    door_next   = D_OPENING;
                    t_load[TD]  = 1'b1;
                    t_value[TD] = MOVE_LOAD;
                end
            end
            D_OPENING: begin
                if (t_zero[TD]) begin
                    door_next   = D_OPEN;
                    t_load[TD]  = 1'b1;
                    t_value[TD] = OPEN_LOAD;
                end else begin
                    t_enable[TD] = 1'b1;
                end
            end
            D_OPEN: begin
                if (hold_btn || t_zero[TD]) begin
                    door_next   = hold_btn ? D_OPEN : D_CLOSING;
                    t_load[TD]  = 1'b1;
                    t_value[TD] = hold_btn ? OPEN_LOAD : MOVE_LOAD;
                end else begin
                    t_enable[TD] = 1'b1;
                end
            end
            D_CLOSING: begin
                // A reopen request wins over closing completion on the same edge.
                if (hold_btn || obstruct) begin
                    door_next     = D_OPENING;
                    t_load[TD]    = 1'b1;
                    t_reverse[TD] = 1'b1;
                    t_value[TD]   = MOVE_LOAD;
                end else if (t_zero[TD]) begin
                    door_next = D_PULSE;
                end else begin
                    t_enable[TD] = 1'b1;
                end
            end
            D_PULSE: door_next = D_WAIT;
            D_WAIT: begin
                if (!opendoor) door_next = D_IDLE;
            end
            default: door_next = D_IDLE;
        endcase
    end

    always_comb begin
        motor_next    = motor_reg;
        t_load[TM]    = 1'b0;
        t_reverse[TM] = 1'b0;
        t_enable[TM]  = 1'b0;
        t_value[TM]   = '0;
        case (motor_reg)
            M_IDLE: begin
                if (mv2nxt && !opendoor && ((door_reg == D_IDLE) || (door_reg == D_WAIT))) begin
                    motor_next  = M_RUN;
                    t_load[TM]  = 1'b1;
                    t_value[TM] = RUN_LOAD;
                end
            end
            M_RUN: begin
                if (t_zero[TM]) motor_next = M_PULSE;
                else            t_enable[TM] = 1'b1;
            end
            M_PULSE: motor_next = M_WAIT;
            M_WAIT: begin
                if (!mv2nxt) motor_next = M_IDLE;
            end
            default: motor_next = M_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            door_reg       <= D_IDLE;
            motor_reg      <= M_IDLE;
            end_open_reg   <= 1'b0;
            end_run_reg    <= 1'b0;
            motor_on_reg   <= 1'b0;
            door_state_reg <= DS_CLOSED;
            interlock_reg  <= 1'b0;
        end else begin
            door_reg       <= door_next;
            motor_reg      <= motor_next;
            end_open_reg   <= (door_next == D_PULSE);
            end_run_reg    <= (motor_next == M_PULSE);
            motor_on_reg   <= (motor_next == M_RUN);
            door_state_reg <= door_code(door_next);
            interlock_reg  <= interlock_reg | (opendoor & mv2nxt);
        end
    end

    assign endOpen    = end_open_reg;
    assign endRun     = end_run_reg;
    assign motor_on   = motor_on_reg;
    assign door_state = door_state_reg;
    assign interlock  = interlock_reg;

endmodule

// File: tb/tb_door_motor_timer.sv
// Directed and randomized check of door_motor_timer against a phase/remaining-time
// reference model evaluated once per clock edge.
module tb_door_motor_timer;

    localparam int DM = 2;
    localparam int OT = 4;
    localparam int RT = 3;

    logic       clk = 1'b0;
    logic       rst, switch, opendoor, mv2nxt, hold_btn, obstruct;
    logic       endOpen, endRun, motor_on, interlock;
    logic [1:0] door_state;

    always #5 clk = ~clk;

    door_motor_timer #(
        .DOOR_MOVE_TICKS (DM),
        .OPEN_TICKS      (OT),
        .RUN_TICKS       (RT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .switch     (switch),
        .opendoor   (opendoor),
        .mv2nxt     (mv2nxt),
        .hold_btn   (hold_btn),
        .obstruct   (obstruct),
        .endOpen    (endOpen),
        .endRun     (endRun),
        .door_state (door_state),
        .motor_on   (motor_on),
        .interlock  (interlock)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: door phase and motor phase with cycles remaining in each.
    localparam int P_IDLE = 0, P_OPENING = 1, P_OPEN = 2, P_CLOSING = 3, P_PULSE = 4, P_WAIT = 5;
    localparam int Q_IDLE = 0, Q_RUN = 1, Q_PULSE = 2, Q_WAIT = 3;
    int dp = P_IDLE, mp = Q_IDLE, drem = 0, mrem = 0;
    bit m_il = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int nd, nm, spent;
        if (rst || !switch) begin
            dp = P_IDLE; mp = Q_IDLE; drem = 0; mrem = 0; m_il = 1'b0;
        end else begin
            nd = dp;
            nm = mp;
            if (opendoor && mv2nxt) m_il = 1'b1;
            case (dp)
                P_IDLE:    if (opendoor && mp == Q_IDLE) begin nd = P_OPENING; drem = DM; end
                P_OPENING: begin drem--; if (drem == 0) begin nd = P_OPEN; drem = OT; end end
                P_OPEN: begin
                    if (hold_btn) drem = OT;
                    else begin drem--; if (drem == 0) begin nd = P_CLOSING; drem = DM; end end
                end
                P_CLOSING: begin
                    if (hold_btn || obstruct) begin
                        spent = DM - drem + 1;
                        nd = P_OPENING;
                        drem = spent;
                    end else begin
                        drem--;
                        if (drem == 0) nd = P_PULSE;
                    end
                end
                P_PULSE: nd = P_WAIT;
                default: if (!opendoor) nd = P_IDLE;
            endcase
            case (mp)
                Q_IDLE: if (mv2nxt && !opendoor && (dp == P_IDLE || dp == P_WAIT)) begin
                    nm = Q_RUN; mrem = RT;
                end
                Q_RUN:   begin mrem--; if (mrem == 0) nm = Q_PULSE; end
                Q_PULSE: nm = Q_WAIT;
                default: if (!mv2nxt) nm = Q_IDLE;
            endcase
            dp = nd;
            mp = nm;
        end
    endtask

    task automatic cycle();
        int exp_ds;
        @(posedge clk);
        model_edge();
        #1;
        exp_ds = (dp == P_OPENING) ? 1 : (dp == P_OPEN) ? 2 : (dp == P_CLOSING) ? 3 : 0;
        check("door_state", 32'(door_state), 32'(exp_ds));
        check("endOpen",    32'(endOpen),    32'(dp == P_PULSE));
        check("endRun",     32'(endRun),     32'(mp == Q_PULSE));
        check("motor_on",   32'(motor_on),   32'(mp == Q_RUN));
        check("interlock",  32'(interlock),  32'(m_il));
        check("pulse_excl", 32'(endOpen && endRun), 32'(0));
        check("motor_door", 32'(motor_on && door_state != 2'b00), 32'(0));
    endtask

    task automatic wait_ds(input logic [1:0] target, input string tag);
        int k = 0;
        while (door_state !== target && k < 60) begin cycle(); k++; end
        check(tag, 32'(door_state), 32'(target));
    endtask

    task automatic run_until_endopen(output int lat);
        lat = 0;
        while (endOpen !== 1'b1 && lat < 100) begin cycle(); lat++; end
        check("endOpen_seen", 32'(endOpen), 32'(1));
    endtask

    initial begin
        int lat, mon, n;
        rst = 1'b1; switch = 1'b1; opendoor = 1'b1; mv2nxt = 1'b0; hold_btn = 1'b0; obstruct = 1'b0;

        // Reset holds everything low even with a request pending
        repeat (3) cycle();
        check("rst_door_state", 32'(door_state), 32'(0));
        rst = 1'b0;
        cycle();
        check("open_after_rst", 32'(door_state), 32'(1));

        // Full door cycle
        run_until_endopen(lat);
        check("endOpen_latency", 32'(lat), 32'(2 * DM + OT));
        repeat (3) cycle();
        check("door_wait_closed", 32'(door_state), 32'(0));
        opendoor = 1'b0;
        repeat (2) cycle();

        // One-floor run
        mv2nxt = 1'b1;
        cycle();
        mon = motor_on ? 1 : 0;
        lat = 0;
        while (endRun !== 1'b1 && lat < 50) begin
            cycle(); lat++;
            if (motor_on) mon++;
        end
        check("endRun_latency", 32'(lat), 32'(RT));
        check("run_cycles", 32'(mon), 32'(RT));
        repeat (3) cycle();
        mv2nxt = 1'b0;
        repeat (2) cycle();

        // Obstruction one cycle into closing
        opendoor = 1'b1;
        cycle();
        lat = 0;
        while (door_state !== 2'b11 && lat < 50) begin cycle(); lat++; end
        obstruct = 1'b1;
        cycle(); lat++;
        obstruct = 1'b0;
        check("obstruct_reopen", 32'(door_state), 32'(1));
        while (endOpen !== 1'b1 && lat < 100) begin cycle(); lat++; end
        check("obstruct_latency", 32'(lat), 32'(2 * DM + 2 * OT + 2));
        opendoor = 1'b0;
        repeat (2) cycle();

        // Hold button during dwell
        opendoor = 1'b1;
        cycle();
        wait_ds(2'b10, "reach_open");
        cycle();
        hold_btn = 1'b1;
        repeat (6) cycle();
        hold_btn = 1'b0;
        n = 0;
        while (door_state !== 2'b11 && n < 50) begin cycle(); n++; end
        check("dwell_after_hold", 32'(n), 32'(OT));
        run_until_endopen(lat);
        opendoor = 1'b0;
        repeat (2) cycle();

        // Simultaneous requests: door wins, interlock latches
        opendoor = 1'b1; mv2nxt = 1'b1;
        cycle();
        check("simul_motor_off", 32'(motor_on), 32'(0));
        check("simul_interlock", 32'(interlock), 32'(1));
        check("simul_door_opening", 32'(door_state), 32'(1));
        run_until_endopen(lat);
        opendoor = 1'b0; mv2nxt = 1'b0;
        repeat (2) cycle();

        // Door request during a run is deferred until the motor is idle again
        mv2nxt = 1'b1;
        cycle();
        mv2nxt = 1'b0; opendoor = 1'b1;
        n = 0;
        while (endRun !== 1'b1 && n < 50) begin cycle(); n++; end
        n = 0;
        while (door_state === 2'b00 && n < 50) begin cycle(); n++; end
        check("deferred_open_delay", 32'(n), 32'(3));
        run_until_endopen(lat);
        opendoor = 1'b0;
        repeat (2) cycle();

        // Master switch off mid-run
        mv2nxt = 1'b1;
        repeat (2) cycle();
        check("run_before_switch", 32'(motor_on), 32'(1));
        switch = 1'b0;
        cycle();
        check("switch_motor_off", 32'(motor_on), 32'(0));
        check("switch_interlock_clr", 32'(interlock), 32'(0));
        switch = 1'b1; mv2nxt = 1'b0;
        repeat (2) cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) opendoor = ~opendoor;
            if ($urandom_range(0, 9) == 0)  mv2nxt = ~mv2nxt;
            hold_btn = ($urandom_range(0, 11) == 0);
            obstruct = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            switch   = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
